// File: rtl/minimig_sram_ctrl.sv
// minimig_sram_ctrl: clocked bridge from the chipset req/ack bus to an
// asynchronous SRAM. Each access runs as a timed SETUP/STROBE/HOLD sequence
// with registered address, data, byte enables and SRAM strobes.
//
// Optional feature: define SRAM_WRPOST_EN to post writes. The write ack then
// comes in the first cycle after accept while the SRAM sequence finishes in
// the background (busy stays high). No ack is given at the end of a posted
// write.
//
// state  | meaning
// IDLE   | no access; SRAM pins inactive; can accept a request
// SETUP  | _ce/address (and write data) valid ahead of the strobe
// STROBE | _oe (read) or _we (write) asserted; read data sampled on last edge
// HOLD   | _ce/address/data held after the strobe; ack in the last cycle

module minimig_sram_ctrl #(
    parameter int DW       = 16,
    parameter int AW       = 22,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                req,
    input  logic [7:0]          bank,
    input  logic [AW:1]         address_in,
    input  logic [DW-1:0]       data_in,
    input  logic                wr,
    input  logic [DW/8-1:0]     be,
    output logic                ack,
    output logic                busy,
    output logic [DW-1:0]       data_out,
    output logic                _ce,
    output logic                _oe,
    output logic                _we,
    output logic [DW/8-1:0]     _be,
    output logic [AW:1]         address,
    output logic [DW-1:0]       data,
    output logic                data_oe,
    input  logic [DW-1:0]       ramdata_in
);

    localparam int NB   = DW / 8;
    localparam int TMAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
    localparam int CW   = $clog2(TMAX + 1);

`ifdef SRAM_WRPOST_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            wr_q, wr_nxt;
    logic [NB-1:0]   be_q, be_nxt;
    logic [DW-1:0]   rd_q, rd_src;
    logic [AW:1]     addr_map;
    logic            accept, unsel, last_nxt;

    // With no setup time the sequence starts directly in STROBE.
    function automatic state_t first_state();
        if (T_SETUP > 0) first_state = SETUP;
        else             first_state = STROBE;
    endfunction

    // Counter reload value for the cycle count of the state being entered.
    function automatic logic [CW-1:0] load_val(input state_t s);
        case (s)
            SETUP:   load_val = CW'((T_SETUP > 0) ? T_SETUP - 1 : 0);
            STROBE:  load_val = CW'(T_STROBE - 1);
            HOLD:    load_val = CW'(T_HOLD - 1);
            default: load_val = '0;
        endcase
    endfunction

    // Next-state decode, accept/unselected detection and bank address remap.
    always_comb begin
        accept = req && (|bank) &&
                 ((state == IDLE) || ((state == HOLD) && (cnt == '0)));
        unsel  = req && !(|bank) && (state == IDLE);

        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = first_state();
            SETUP:   if (cnt == '0) state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = HOLD;
            HOLD: begin
                if (cnt == '0) begin
                    if (accept) state_nxt = first_state();
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE)       cnt_nxt = '0;
        else if (state_nxt != state) cnt_nxt = load_val(state_nxt);
        else                         cnt_nxt = cnt - CW'(1);

        wr_nxt   = accept ? wr : wr_q;
        be_nxt   = accept ? be : be_q;
        last_nxt = (state_nxt == HOLD) && (cnt_nxt == '0);

        // With a one-cycle HOLD the capture edge and the ack-cycle entry
        // coincide, so the pad value bypasses the capture register.
        rd_src = (state == STROBE) ? ramdata_in : rd_q;

        addr_map = address_in;
        if (bank[7] | bank[6])
            addr_map[22:18] = {3'b111, bank[7], address_in[18]};
        else if (bank[5])
            addr_map[22:18] = {2'b00, bank[3] | bank[2], bank[3] | bank[1], address_in[18]};
    end

    // Sequencer state, latched access fields and registered SRAM/bus outputs.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            rd_q     <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            data_out <= '0;
            _ce      <= 1'b1;
            _oe      <= 1'b1;
            _we      <= 1'b1;
            _be      <= '1;
            data_oe  <= 1'b0;
            address  <= '0;
            data     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= wr;
                be_q    <= be;
                address <= addr_map;
                data    <= data_in;
            end
            if ((state == STROBE) && (cnt == '0))
                rd_q <= ramdata_in;

            busy    <= (state_nxt != IDLE);
            _ce     <= (state_nxt == IDLE);
            _oe     <= !(!wr_nxt && ((state_nxt == SETUP) || (state_nxt == STROBE)));
            _we     <= !(wr_nxt && (state_nxt == STROBE));
            _be     <= (state_nxt == IDLE) ? '1 : (wr_nxt ? ~be_nxt : '0);
            data_oe <= wr_nxt && (state_nxt != IDLE);

            ack      <= unsel || (last_nxt && !(POST && wr_nxt)) || (POST && accept && wr);
            data_out <= (last_nxt && !wr_nxt) ? rd_src : '0;
        end
    end

endmodule

// File: tb/tb_minimig_sram_ctrl.sv
// Bench for minimig_sram_ctrl: a table of single accesses with hand-computed
// expectations, then hand-written sequences for unselected requests,
// back-to-back accesses, reset in mid-strobe and (if enabled) posted writes.

module tb_minimig_sram_ctrl;

    localparam int DW = 16;
    localparam int AW = 22;
    localparam int NB = DW / 8;

    logic            clk = 1'b0;
    logic            _reset;
    logic            req;
    logic [7:0]      bank;
    logic [AW:1]     address_in;
    logic [DW-1:0]   data_in;
    logic            wr;
    logic [NB-1:0]   be;
    logic            ack;
    logic            busy;
    logic [DW-1:0]   data_out;
    logic            _ce;
    logic            _oe;
    logic            _we;
    logic [NB-1:0]   _be;
    logic [AW:1]     address;
    logic [DW-1:0]   data;
    logic            data_oe;
    logic [DW-1:0]   ramdata_in;

    int checks = 0;
    int errors = 0;

    minimig_sram_ctrl #(.DW(DW), .AW(AW), .T_SETUP(1), .T_STROBE(2), .T_HOLD(1)) dut (
        .clk        (clk),
        ._reset     (_reset),
        .req        (req),
        .bank       (bank),
        .address_in (address_in),
        .data_in    (data_in),
        .wr         (wr),
        .be         (be),
        .ack        (ack),
        .busy       (busy),
        .data_out   (data_out),
        ._ce        (_ce),
        ._oe        (_oe),
        ._we        (_we),
        ._be        (_be),
        .address    (address),
        .data       (data),
        .data_oe    (data_oe),
        .ramdata_in (ramdata_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    bank;
        logic [AW:1]   addr;
        logic          wr;
        logic [NB-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [AW:1]   exp_addr;
        logic [NB-1:0] exp_be_n;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [7:0] b, input logic [AW:1] a, input logic w,
                             input logic [NB-1:0] e, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rd);
        req        = 1'b1;
        bank       = b;
        address_in = a;
        wr         = w;
        be         = e;
        data_in    = wd;
        ramdata_in = rd;
    endtask

    // One access from the table; cycle c is the c-th cycle after the accept edge.
    task automatic run_vec(input int idx);
        vec_t          v;
        logic [6:0]    ack_v, oe_v, we_v, ce_v, doe_v, busy_v, exp_ack;
        logic [DW-1:0] dout_ack, dout_rest, data_s;
        logic [AW:1]   addr_s;
        logic [NB-1:0] be_s;
        v = vecs[idx];
        ack_v = '0; oe_v = '0; we_v = '0; ce_v = '0; doe_v = '0; busy_v = '0;
        dout_ack = '0; dout_rest = '0; data_s = '0; addr_s = '0; be_s = '0;
        @(posedge clk); #1;
        drive_req(v.bank, v.addr, v.wr, v.be, v.wdata, v.rdata);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ack_v[c]  = ack;
            oe_v[c]   = ~_oe;
            we_v[c]   = ~_we;
            ce_v[c]   = ~_ce;
            doe_v[c]  = data_oe;
            busy_v[c] = busy;
            if (c == 4) dout_ack = data_out;
            else        dout_rest = dout_rest | data_out;
            if (c == 2) begin
                addr_s = address;
                be_s   = _be;
                data_s = data;
            end
            if (ack) req = 1'b0;
        end
        req = 1'b0;
        exp_ack = 7'b0010000;
`ifdef SRAM_WRPOST_EN
        if (v.wr) exp_ack = 7'b0000010;
`endif
        chk($sformatf("v%0d ack_cycles", idx), ack_v, exp_ack);
        chk($sformatf("v%0d oe_low", idx), oe_v, v.wr ? 7'b0000000 : 7'b0001110);
        chk($sformatf("v%0d we_low", idx), we_v, v.wr ? 7'b0001100 : 7'b0000000);
        chk($sformatf("v%0d ce_low", idx), ce_v, 7'b0011110);
        chk($sformatf("v%0d data_oe", idx), doe_v, v.wr ? 7'b0011110 : 7'b0000000);
        chk($sformatf("v%0d busy", idx), busy_v, 7'b0011110);
        chk($sformatf("v%0d address", idx), addr_s, v.exp_addr);
        chk($sformatf("v%0d be_n", idx), be_s, v.exp_be_n);
        chk($sformatf("v%0d dout_ack", idx), dout_ack, v.exp_dout);
        chk($sformatf("v%0d dout_other", idx), dout_rest, '0);
        if (v.wr) chk($sformatf("v%0d wdata", idx), data_s, v.wdata);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [9:0]    b_ack, b_ce, b_oe, b_we, b_ovl, exp_b_ack;
        logic [3:0]    u_ack, u_ce;
        logic [DW-1:0] b_dout;

        //                bank   addr_in      wr    be     wdata     rdata     exp_addr     _be    dout
        vecs[0] = '{8'h01, 22'h000123, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 22'h000123, 2'b00, 16'hBEEF};
        vecs[1] = '{8'h01, 22'h000456, 1'b1, 2'b10, 16'h1234, 16'h0000, 22'h000456, 2'b01, 16'h0000};
        vecs[2] = '{8'h80, 22'h020ABC, 1'b0, 2'b11, 16'h0000, 16'h8001, 22'h3E0ABC, 2'b00, 16'h8001};
        vecs[3] = '{8'h28, 22'h1D5555, 1'b1, 2'b01, 16'hA5C3, 16'hFFFF, 22'h0D5555, 2'b10, 16'h0000};
        vecs[4] = '{8'h40, 22'h000001, 1'b0, 2'b00, 16'h0000, 16'h0F0F, 22'h380001, 2'b00, 16'h0F0F};
        vecs[5] = '{8'h02, 22'h3C1234, 1'b0, 2'b01, 16'h0000, 16'h5A5A, 22'h3C1234, 2'b00, 16'h5A5A};

        _reset = 1'b0;
        req = 1'b0; bank = '0; address_in = '0; wr = 1'b0; be = '0;
        data_in = '0; ramdata_in = '0;
        #12;
        chk("reset ack_busy", {ack, busy}, 2'b00);
        chk("reset data_out", data_out, '0);
        chk("reset strobes", {_ce, _oe, _we, data_oe}, 4'b1110);
        chk("reset be_n", _be, 2'b11);
        chk("reset address", address, '0);
        chk("reset data", data, '0);
        @(negedge clk);
        _reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Unselected request: ack next cycle, no SRAM activity.
        @(posedge clk); #1;
        drive_req(8'h00, 22'h000123, 1'b0, 2'b11, 16'h0000, 16'hFFFF);
        @(posedge clk);
        u_ack = '0; u_ce = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            u_ack[c] = ack;
            u_ce[c]  = _ce & _oe & _we;
            if (c == 0) chk("unsel data_out", data_out, '0);
            if (ack) req = 1'b0;
        end
        req = 1'b0;
        chk("unsel ack_cycles", u_ack, 4'b0001);
        chk("unsel pins_idle", u_ce, 4'b1111);
        repeat (2) @(posedge clk);

        // Back-to-back read then write with req held through the ack cycle.
        @(posedge clk); #1;
        drive_req(8'h01, 22'h000010, 1'b0, 2'b11, 16'h0000, 16'hCAFE);
        @(posedge clk);
        b_ack = '0; b_ce = '0; b_oe = '0; b_we = '0; b_ovl = '0; b_dout = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            b_ack[c] = ack;
            b_ce[c]  = ~_ce;
            b_oe[c]  = ~_oe;
            b_we[c]  = ~_we;
            b_ovl[c] = ~_oe & ~_we;
            if (c == 4) begin
                b_dout = data_out;
                drive_req(8'h01, 22'h000020, 1'b1, 2'b11, 16'h7777, 16'h0000);
            end else if (ack) begin
                req = 1'b0;
            end
        end
        req = 1'b0;
        exp_b_ack = 10'b0100010000;
`ifdef SRAM_WRPOST_EN
        exp_b_ack = 10'b0000110000;
`endif
        chk("b2b read_dout", b_dout, 16'hCAFE);
        chk("b2b ack_cycles", b_ack, exp_b_ack);
        chk("b2b ce_low", b_ce, 10'b0111111110);
        chk("b2b oe_low", b_oe, 10'b0000001110);
        chk("b2b we_low", b_we, 10'b0011000000);
        chk("b2b oe_we_overlap", b_ovl, '0);
        chk("b2b wdata", data, 16'h7777);
        repeat (2) @(posedge clk);

        // Reset asserted during the STROBE of a write.
        @(posedge clk); #1;
        drive_req(8'h01, 22'h000055, 1'b1, 2'b11, 16'h9999, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst we_in_strobe", _we, 1'b0);
        _reset = 1'b0;
        #1;
        chk("rst async_inactive", {_we, _ce, data_oe, busy}, 4'b1100);
        req = 1'b0;
        u_ack = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        _reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            u_ack[c] = ack;
        end
        chk("rst no_ack", u_ack, 4'b0000);
        run_vec(0);

`ifdef SRAM_WRPOST_EN
        // Posted write, then a read raised while the write is still running.
        @(posedge clk); #1;
        drive_req(8'h01, 22'h000077, 1'b1, 2'b11, 16'h4321, 16'h1357);
        @(posedge clk);
        b_ack = '0; b_ce = '0; b_dout = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            b_ack[c] = ack;
            b_ce[c]  = busy;
            if (c == 8) b_dout = data_out;
            if (c == 2) drive_req(8'h01, 22'h000078, 1'b0, 2'b11, 16'h0000, 16'h1357);
            else if (ack) req = 1'b0;
        end
        req = 1'b0;
        chk("post ack_cycles", b_ack, 10'b0100000010);
        chk("post busy", b_ce, 10'b0111111110);
        chk("post read_dout", b_dout, 16'h1357);
        repeat (2) @(posedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
